fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each requester word and of the FIFO write data.
REQ-002 Parameter N_REQ, default 4, number of requesters (2..16).
REQ-003 Port clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 Port rst_i  input  1  reset; synchronous, active-high.
REQ-005 Port req_i  input  N_REQ  per-requester write request, held high until the matching ack.
REQ-006 Port data_i  input  N_REQ*DATA_WIDTH  requester k word at bits [k*DATA_WIDTH +: DATA_WIDTH], held stable while req_i[k] is high.
REQ-007 Port ack_o  output  N_REQ  one-cycle pulse when the requester word is captured.
REQ-008 Port fifo_w_en_o  output  1  write enable to the shared sync FIFO (FIFO registers it internally, one cycle of latency).
REQ-009 Port fifo_data_o  output  DATA_WIDTH  write data to the FIFO.
REQ-010 Port fifo_full_i  input  1  FIFO full flag.
REQ-011 Port busy_o  output  1  high whenever state is not IDLE.
REQ-012 Port wr_count_o  output  16  number of grants since reset, wraps modulo 2^16.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, SETTLE; all outputs are registered.
REQ-014 In IDLE, a grant SHALL occur when any req_i bit is high and fifo_full_i is low; otherwise it SHALL remain in IDLE with no output change.
REQ-015 The winner SHALL be the first requester with req_i high, searching upward from (last_grant+1) mod N_REQ and wrapping; last_grant resets to N_REQ-1, so requester 0 has first priority.
REQ-016 On the grant edge: data register <= winner word, fifo_w_en_o <= 1, ack_o[winner] <= 1, last_grant <= winner, wr_count_o increments, state -> ISSUE.
REQ-017 In ISSUE (exactly one cycle), fifo_w_en_o and ack_o SHALL be high; on exit both SHALL clear, state -> SETTLE.
REQ-018 In SETTLE (exactly one cycle, during which the FIFO performs the write), req_i SHALL be ignored; state -> IDLE.
REQ-019 fifo_data_o SHALL change only on a grant edge and hold its value through ISSUE and SETTLE until the next grant.
REQ-020 Grants SHALL be separated by at least 3 cycles, so fifo_full_i sampled in IDLE reflects every prior write; the block SHALL never issue a write the FIFO would drop.
REQ-021 At most one ack_o bit SHALL be high in any cycle; fifo_w_en_o SHALL never be high for two consecutive cycles.
REQ-022 A requester dropping req_i before its ack SHALL be treated as withdrawn, with no capture and no ack.
REQ-023 If fifo_full_i is high in IDLE, all requesters SHALL stall; the round-robin pointer is unchanged.
REQ-024 A single requester held high continuously SHALL be granted every 3 cycles.

Reset
REQ-025 While rst_i is high at a clock edge: state <= IDLE, fifo_w_en_o <= 0, ack_o <= 0, fifo_data_o <= 0, last_grant <= N_REQ-1, wr_count_o <= 0, busy_o <= 0.
REQ-026 Reset asserted in ISSUE or SETTLE SHALL abort the transaction with no further ack and no w_en pulse; the aborted grant remains counted only until the reset clears wr_count_o.

Verification
REQ-027 Reset, then req_i=4'b0001 with word0=0xA5A5A5A5 and FIFO not full -> grant edge, then one cycle with fifo_w_en_o=1 and ack_o=4'b0001; fifo_data_o=0xA5A5A5A5 held; wr_count_o=1.
REQ-028 req_i=4'b1111 held, each requester dropping req on its ack and reasserting 3 cycles later -> grant order 0,1,2,3,0, spaced 3 cycles apart; no two ack bits high together.
REQ-029 fifo_full_i=1 with req_i=4'b0100 for 10 cycles -> fifo_w_en_o=0, ack_o=0, busy_o=0; full drops -> requester 2 granted on the next edge.
REQ-030 With the arbiter connected to a 16-entry sync FIFO (15 usable), 20 back-to-back requests from requester 1 and no reads -> exactly 15 grants, wr_count_o=15, no dropped write, arbiter stalled in IDLE.
REQ-031 rst_i pulsed for one cycle while in ISSUE -> ack_o and fifo_w_en_o low from the next cycle, state IDLE, wr_count_o=0, next grant goes to requester 0 if it is requesting.
REQ-032 Requester 3 drops req_i one cycle before it would win -> no ack_o[3]; the next requesting index wins.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time into a shared sync FIFO,
// spacing grants three cycles apart so the FIFO full flag is always current when sampled.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]            ack_o,
    output logic                        fifo_w_en_o,
    output logic [DATA_WIDTH-1:0]       fifo_data_o,
    input  logic                        fifo_full_i,
    output logic                        busy_o,
    output logic [15:0]                 wr_count_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    // Search downward in offset so the requester closest after last_grant is assigned last and wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = int'(last_grant) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (req_i[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            fifo_w_en_o <= 1'b0;
            ack_o       <= '0;
            fifo_data_o <= '0;
            last_grant  <= IDX_W'(N_REQ - 1);
            wr_count_o  <= 16'd0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid && !fifo_full_i) begin
                        fifo_data_o <= data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                        fifo_w_en_o <= 1'b1;
                        ack_o       <= N_REQ'(1) << grant_idx;
                        last_grant  <= grant_idx;
                        wr_count_o  <= wr_count_o + 16'd1;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    fifo_w_en_o <= 1'b0;
                    ack_o       <= '0;
                    state       <= SETTLE;
                end
                // The FIFO commits the write during this cycle; requests are not looked at.
                SETTLE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    fifo_w_en_o <= 1'b0;
                    ack_o       <= '0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a grant-spacing/round-robin reference model.
module tb_fifo_wr_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   ack;
    logic           wen;
    logic [W-1:0]   fdata;
    logic           full;
    logic           full_manual;
    logic           use_fifo;
    logic           busy;
    logic [15:0]    count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(W), .N_REQ(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .data_i      (data),
        .ack_o       (ack),
        .fifo_w_en_o (wen),
        .fifo_data_o (fdata),
        .fifo_full_i (full),
        .busy_o      (busy),
        .wr_count_o  (count)
    );

    // 16-entry FIFO with 15 usable slots; a write while full is counted as a drop.
    int fifo_cnt;
    int fifo_drops;
    assign full = use_fifo ? (fifo_cnt == 15) : full_manual;

    always @(posedge clk) begin
        if (rst) begin
            fifo_cnt   <= 0;
            fifo_drops <= 0;
        end else if (use_fifo && wen) begin
            if (fifo_cnt == 15) fifo_drops <= fifo_drops + 1;
            else                fifo_cnt   <= fifo_cnt + 1;
        end
    end

    // Reference model: after a grant, two cycles must pass before the next decision.
    int          m_wait;
    int          m_last;
    logic [15:0] m_count;
    logic [N-1:0] m_ack;
    logic        m_wen;
    logic [W-1:0] m_data;
    logic        m_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_wait = 0; m_last = N - 1; m_count = 0;
            m_ack = 0; m_wen = 0; m_data = 0;
        end else begin
            m_ack = 0;
            m_wen = 0;
            if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (req != 0 && !full) begin
                for (int off = 1; off <= N; off++) begin
                    int k;
                    k = (m_last + off) % N;
                    if (req[k] && m_wen == 1'b0) begin
                        m_ack   = 0;
                        m_ack[k] = 1'b1;
                        m_wen   = 1'b1;
                        m_data  = data[k*W +: W];
                        m_last  = k;
                        m_count = m_count + 16'd1;
                        m_wait  = 2;
                    end
                end
            end
        end
        m_busy = (m_wait > 0);
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; data = '0; full_manual = 1'b0; use_fifo = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack got=%b exp=0000", ack); end
        checks++;
        if (wen !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen got=%b exp=0", wen); end
        checks++;
        if (fdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", fdata); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        data[0*W +: W] = 32'hA5A5A5A5;
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001 || wen !== 1'b1) begin
            failures++; $display("[TB] FAIL single_issue got ack=%b wen=%b exp ack=0001 wen=1", ack, wen);
        end
        checks++;
        if (fdata !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL single_data got=%h exp=a5a5a5a5", fdata); end
        checks++;
        if (count !== 16'd1 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL single_count got count=%0d busy=%b exp 1/1", count, busy);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || wen !== 1'b0 || fdata !== 32'hA5A5A5A5 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL single_settle got ack=%b wen=%b data=%h busy=%b exp 0000/0/a5a5a5a5/1", ack, wen, fdata, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fdata !== 32'hA5A5A5A5 || count !== 16'd1) begin
            failures++; $display("[TB] FAIL single_idle got busy=%b data=%h count=%0d exp 0/a5a5a5a5/1", busy, fdata, count);
        end
    endtask

    task automatic test_round_robin();
        int timer[N];
        int grants;
        int last_c;
        do_reset();
        for (int k = 0; k < N; k++) timer[k] = 0;
        grants = 0; last_c = 0;
        req = 4'b1111;
        for (int c = 0; c < 20 && grants < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (timer[k] > 0) begin
                    timer[k]--;
                    if (timer[k] == 0) req[k] = 1'b1;
                end
            end
            checks++;
            if ($countones(ack) > 1) begin failures++; $display("[TB] FAIL rr_onehot got ack=%b exp at most one bit", ack); end
            if (ack != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (ack[k]) begin
                        checks++;
                        if (k != grants % N) begin
                            failures++; $display("[TB] FAIL rr_order got=%0d exp=%0d", k, grants % N);
                        end
                        if (grants > 0) begin
                            checks++;
                            if (c - last_c != 3) begin
                                failures++; $display("[TB] FAIL rr_spacing got=%0d exp=3", c - last_c);
                            end
                        end
                        req[k] = 1'b0;
                        timer[k] = 3;
                    end
                end
                grants++;
                last_c = c;
            end
        end
        checks++;
        if (grants != 5) begin failures++; $display("[TB] FAIL rr_grants got=%0d exp=5", grants); end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_stall();
        do_reset();
        full_manual = 1'b1;
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (wen !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin
                failures++; $display("[TB] FAIL full_stall got wen=%b ack=%b busy=%b exp 0/0000/0", wen, ack, busy);
            end
        end
        full_manual = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100 || wen !== 1'b1) begin
            failures++; $display("[TB] FAIL full_release got ack=%b wen=%b exp 0100/1", ack, wen);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fifo_fill();
        int grants;
        int issued;
        use_fifo = 1'b1;
        do_reset();
        grants = 0;
        issued = 1;
        req = 4'b0010;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (ack[1]) begin
                grants++;
                req[1] = 1'b0;
            end else if (!req[1] && issued < 20) begin
                req[1] = 1'b1;
                issued++;
            end
        end
        checks++;
        if (grants != 15) begin failures++; $display("[TB] FAIL fill_grants got=%0d exp=15", grants); end
        checks++;
        if (count !== 16'd15) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=15", count); end
        checks++;
        if (fifo_drops != 0 || fifo_cnt != 15) begin
            failures++; $display("[TB] FAIL fill_fifo got drops=%0d level=%0d exp 0/15", fifo_drops, fifo_cnt);
        end
        checks++;
        if (busy !== 1'b0 || wen !== 1'b0) begin
            failures++; $display("[TB] FAIL fill_stalled got busy=%b wen=%b exp 0/0", busy, wen);
        end
        req = '0;
        use_fifo = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100) begin failures++; $display("[TB] FAIL abort_grant got=%b exp=0100", ack); end
        rst = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || wen !== 1'b0 || busy !== 1'b0 || count !== 16'd0 || fdata !== 32'h0) begin
            failures++; $display("[TB] FAIL abort_clear got ack=%b wen=%b busy=%b count=%0d data=%h exp 0000/0/0/0/0", ack, wen, busy, count, fdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL abort_pointer got=%b exp=0001", ack); end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b1010;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin failures++; $display("[TB] FAIL withdraw_first got=%b exp=0010", ack); end
        req = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL withdraw_idle got ack=%b busy=%b exp 0000/0", ack, busy);
        end
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001) begin failures++; $display("[TB] FAIL withdraw_next got=%b exp=0001", ack); end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic prev_wen;
        do_reset();
        prev_wen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (ack !== m_ack) begin failures++; $display("[TB] FAIL rand_ack cycle=%0d got=%b exp=%b", c, ack, m_ack); end
            checks++;
            if (wen !== m_wen) begin failures++; $display("[TB] FAIL rand_wen cycle=%0d got=%b exp=%b", c, wen, m_wen); end
            checks++;
            if (fdata !== m_data) begin failures++; $display("[TB] FAIL rand_data cycle=%0d got=%h exp=%h", c, fdata, m_data); end
            checks++;
            if (busy !== m_busy) begin failures++; $display("[TB] FAIL rand_busy cycle=%0d got=%b exp=%b", c, busy, m_busy); end
            checks++;
            if (count !== m_count) begin failures++; $display("[TB] FAIL rand_count cycle=%0d got=%0d exp=%0d", c, count, m_count); end
            checks++;
            if (prev_wen && wen) begin failures++; $display("[TB] FAIL rand_wen_twice cycle=%0d got=1 exp=0", c); end
            prev_wen = wen;
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < N; k++) begin
                if (req[k] && ack[k]) begin
                    req[k] = 1'b0;
                end else if (req[k]) begin
                    if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[k] = 1'b1;
                    data[k*W +: W] = $urandom;
                end
            end
            full_manual = ($urandom_range(0, 4) == 0);
        end
        rst = 1'b0;
        req = '0;
        full_manual = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_fifo_fill();
        test_reset_abort();
        test_withdraw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
